// File: rtl/h2c_stream_checker_64.sv
`default_nettype none
// ============================================================================
//  Module   : h2c_stream_checker_64
//  Purpose  : AXI4-Stream sink that verifies the 64-bit counter-pattern
//             packet stream from the ADC data producer. Checks packet length,
//             tkeep and data pattern. Provides throttled back-pressure,
//             wrapping packet/beat counters, saturating error counters and
//             first-data-error capture.
//  Ports    : user_clk, user_rstn (async, active low)
//             chk_ena        - level; rising edge clears stats, high = check
//             throttle[3:0]  - 0: tready always high, N: low 1 of N+1 cycles
//             s_axis_*       - stream sink (tready registered)
//             pkt_count      - tlast beats accepted since enable (wraps)
//             beat_count     - beats accepted since enable (wraps)
//             data/len/keep_err_count - saturating error counters
//             err_flag       - sticky, any error since enable
//             first_err_exp/rcv - words captured at the first data error
//             pkt_done       - one-cycle pulse per accepted tlast beat
//  Revision : 1.0 - initial release
// ============================================================================
module h2c_stream_checker_64 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int PKT_WORDS  = 2048,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rstn,
  input  logic                  chk_ena,
  input  logic [3:0]            throttle,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [31:0]           pkt_count,
  output logic [31:0]           beat_count,
  output logic [ERR_WIDTH-1:0]  data_err_count,
  output logic [ERR_WIDTH-1:0]  len_err_count,
  output logic [ERR_WIDTH-1:0]  keep_err_count,
  output logic                  err_flag,
  output logic [63:0]           first_err_exp,
  output logic [63:0]           first_err_rcv,
  output logic                  pkt_done
);

  localparam int                    c_IDX_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(PKT_WORDS - 1);
  localparam logic [ERR_WIDTH-1:0]  c_ERR_MAX  = '1;
  localparam logic [KEEP_WIDTH-1:0] c_KEEP_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Back-pressure generator. The throttle setting is only sampled when the
  // counter wraps, so a period in progress always completes with its old N.
  // tready is computed from the next counter value so that the registered
  // tready lines up with the registered count.
  // --------------------------------------------------------------------------
  logic [3:0] r_thr_cnt;
  logic [3:0] r_thr_lat;
  logic [3:0] w_thr_cnt_nxt;
  logic [3:0] w_thr_lat_nxt;
  logic       w_thr_wrap;
  logic       w_tready_nxt;
  logic       r_tready;

  always_comb begin
    w_thr_wrap    = (r_thr_cnt >= r_thr_lat);
    w_thr_cnt_nxt = w_thr_wrap ? 4'd0 : (r_thr_cnt + 4'd1);
    w_thr_lat_nxt = w_thr_wrap ? throttle : r_thr_lat;
    w_tready_nxt  = (w_thr_lat_nxt == 4'd0) || (w_thr_cnt_nxt != w_thr_lat_nxt);
  end

  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      r_thr_cnt <= 4'd0;
      r_thr_lat <= 4'd0;
      r_tready  <= 1'b0;
    end else begin
      r_thr_cnt <= w_thr_cnt_nxt;
      r_thr_lat <= w_thr_lat_nxt;
      r_tready  <= w_tready_nxt;
    end
  end

  assign s_axis_tready = r_tready;

  // --------------------------------------------------------------------------
  // Beat qualification. A beat only counts while chk_ena is high; in IDLE
  // with chk_ena high (the rising-edge cycle) the beat is the SYNC beat.
  // --------------------------------------------------------------------------
  logic r_ena_d;
  logic w_ena_rise;
  logic w_beat;
  logic w_sync_beat;
  logic w_run_beat;

  assign w_ena_rise  = chk_ena & ~r_ena_d;
  assign w_beat      = s_axis_tvalid & r_tready & chk_ena;
  assign w_sync_beat = w_beat & (r_state != ST_RUN);
  assign w_run_beat  = w_beat & (r_state == ST_RUN);

  // FSM state register
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      r_state <= ST_IDLE;
      r_ena_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ena_d <= chk_ena;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    if (!chk_ena) begin
      w_state_nxt = ST_IDLE;
    end else if (w_sync_beat) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = ST_SYNC;
    end
  end

  // --------------------------------------------------------------------------
  // Checks
  // --------------------------------------------------------------------------
  logic [31:0]          r_seq;
  logic [c_IDX_W-1:0]   r_idx;
  logic [63:0]          w_exp;
  logic [c_IDX_W-1:0]   w_idx_base;
  logic                 w_data_err;
  logic                 w_len_err;
  logic                 w_keep_err;
  logic                 w_any_err;

  // Expected word layout: {c[29:0], 1, c[31:0], 0}
  assign w_exp = {r_seq[29:0], 1'b1, r_seq, 1'b0};

  // The SYNC beat is always packet index 0.
  assign w_idx_base = w_sync_beat ? '0 : r_idx;

  assign w_data_err = w_run_beat & (s_axis_tdata != w_exp);
  assign w_len_err  = w_beat & (s_axis_tlast != (w_idx_base == c_LAST_IDX));
  assign w_keep_err = w_beat & (s_axis_tkeep != c_KEEP_ALL);
  assign w_any_err  = w_data_err | w_len_err | w_keep_err;

  // --------------------------------------------------------------------------
  // Statistics. On the enable rising edge every statistic restarts from zero
  // and the beat of that same cycle (if any) is applied on top.
  // --------------------------------------------------------------------------
  logic [31:0]          r_pkt_cnt;
  logic [31:0]          r_beat_cnt;
  logic [ERR_WIDTH-1:0] r_derr;
  logic [ERR_WIDTH-1:0] r_lerr;
  logic [ERR_WIDTH-1:0] r_kerr;
  logic                 r_err_flag;
  logic                 r_cap_valid;
  logic [63:0]          r_cap_exp;
  logic [63:0]          r_cap_rcv;
  logic                 r_pkt_done;

  logic [31:0]          w_pkt_base;
  logic [31:0]          w_beat_base;
  logic [ERR_WIDTH-1:0] w_derr_base;
  logic [ERR_WIDTH-1:0] w_lerr_base;
  logic [ERR_WIDTH-1:0] w_kerr_base;
  logic                 w_flag_base;
  logic                 w_cap_valid_base;

  assign w_pkt_base       = w_ena_rise ? 32'd0 : r_pkt_cnt;
  assign w_beat_base      = w_ena_rise ? 32'd0 : r_beat_cnt;
  assign w_derr_base      = w_ena_rise ? '0    : r_derr;
  assign w_lerr_base      = w_ena_rise ? '0    : r_lerr;
  assign w_kerr_base      = w_ena_rise ? '0    : r_kerr;
  assign w_flag_base      = w_ena_rise ? 1'b0  : r_err_flag;
  assign w_cap_valid_base = w_ena_rise ? 1'b0  : r_cap_valid;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(
    input logic [ERR_WIDTH-1:0] v,
    input logic                 en
  );
    return (en && (v != c_ERR_MAX)) ? (v + 1'b1) : v;
  endfunction

  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      r_seq       <= 32'd0;
      r_idx       <= '0;
      r_pkt_cnt   <= 32'd0;
      r_beat_cnt  <= 32'd0;
      r_derr      <= '0;
      r_lerr      <= '0;
      r_kerr      <= '0;
      r_err_flag  <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_exp   <= 64'd0;
      r_cap_rcv   <= 64'd0;
      r_pkt_done  <= 1'b0;
    end else begin
      // Sequence tracking: seed from the SYNC beat, then one step per beat.
      if (w_sync_beat) begin
        r_seq <= s_axis_tdata[32:1] + 32'd1;
      end else if (w_run_beat) begin
        r_seq <= r_seq + 32'd1;
      end

      // Packet index: any tlast or the last slot forces a boundary.
      if (w_beat) begin
        if (s_axis_tlast || (w_idx_base == c_LAST_IDX)) begin
          r_idx <= '0;
        end else begin
          r_idx <= w_idx_base + 1'b1;
        end
      end

      r_pkt_cnt  <= w_pkt_base + {31'd0, w_beat & s_axis_tlast};
      r_beat_cnt <= w_beat_base + {31'd0, w_beat};
      r_derr     <= sat_inc(w_derr_base, w_data_err);
      r_lerr     <= sat_inc(w_lerr_base, w_len_err);
      r_kerr     <= sat_inc(w_kerr_base, w_keep_err);
      r_err_flag <= w_flag_base | w_any_err;
      r_pkt_done <= w_beat & s_axis_tlast;

      // Capture freezes after the first data error until re-enable.
      if (w_data_err && !w_cap_valid_base) begin
        r_cap_valid <= 1'b1;
        r_cap_exp   <= w_exp;
        r_cap_rcv   <= s_axis_tdata;
      end else if (w_ena_rise) begin
        r_cap_valid <= 1'b0;
        r_cap_exp   <= 64'd0;
        r_cap_rcv   <= 64'd0;
      end
    end
  end

  assign pkt_count      = r_pkt_cnt;
  assign beat_count     = r_beat_cnt;
  assign data_err_count = r_derr;
  assign len_err_count  = r_lerr;
  assign keep_err_count = r_kerr;
  assign err_flag       = r_err_flag;
  assign first_err_exp  = r_cap_exp;
  assign first_err_rcv  = r_cap_rcv;
  assign pkt_done       = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_h2c_stream_checker_64.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_h2c_stream_checker_64
//  Purpose  : Self-checking bench for h2c_stream_checker_64. A second
//             instance with 4-bit error counters shares all inputs to
//             observe counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_h2c_stream_checker_64;

  localparam int c_PKT = 2048;

  logic        user_clk      = 1'b0;
  logic        user_rstn     = 1'b0;
  logic        chk_ena       = 1'b0;
  logic [3:0]  throttle      = 4'd0;
  logic [63:0] s_axis_tdata  = 64'd0;
  logic [7:0]  s_axis_tkeep  = 8'hFF;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast  = 1'b0;

  logic        s_axis_tready;
  logic [31:0] pkt_count, beat_count;
  logic [15:0] data_err_count, len_err_count, keep_err_count;
  logic        err_flag, pkt_done;
  logic [63:0] first_err_exp, first_err_rcv;

  logic        sat_tready;
  logic [31:0] sat_pkt_count, sat_beat_count;
  logic [3:0]  sat_data_err, sat_len_err, sat_keep_err;
  logic        sat_err_flag, sat_pkt_done;
  logic [63:0] sat_first_exp, sat_first_rcv;

  always #5 user_clk = ~user_clk;

  h2c_stream_checker_64 #(.PKT_WORDS(c_PKT), .ERR_WIDTH(16)) u_dut (
    .user_clk(user_clk), .user_rstn(user_rstn), .chk_ena(chk_ena),
    .throttle(throttle), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .pkt_count(pkt_count), .beat_count(beat_count),
    .data_err_count(data_err_count), .len_err_count(len_err_count),
    .keep_err_count(keep_err_count), .err_flag(err_flag),
    .first_err_exp(first_err_exp), .first_err_rcv(first_err_rcv),
    .pkt_done(pkt_done)
  );

  h2c_stream_checker_64 #(.PKT_WORDS(c_PKT), .ERR_WIDTH(4)) u_dut_sat (
    .user_clk(user_clk), .user_rstn(user_rstn), .chk_ena(chk_ena),
    .throttle(throttle), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(sat_tready),
    .s_axis_tlast(s_axis_tlast), .pkt_count(sat_pkt_count), .beat_count(sat_beat_count),
    .data_err_count(sat_data_err), .len_err_count(sat_len_err),
    .keep_err_count(sat_keep_err), .err_flag(sat_err_flag),
    .first_err_exp(sat_first_exp), .first_err_rcv(sat_first_rcv),
    .pkt_done(sat_pkt_done)
  );

  // Scoreboard counts
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_ena = 0;
  bit          m_seeded = 0;
  logic [31:0] m_seq = 0;
  int          m_pos = 0;
  logic [31:0] m_pkt = 0, m_beat = 0;
  int          m_derr = 0, m_lerr = 0, m_kerr = 0;
  bit          m_flag = 0, m_cap = 0;
  logic [63:0] m_cexp = 0, m_crcv = 0;
  int          m_done = 0;
  int          done_seen = 0;

  always @(negedge user_clk) if (pkt_done === 1'b1) done_seen++;

  function automatic logic [63:0] pat(input logic [31:0] c);
    return {c[29:0], 1'b1, c, 1'b0};
  endfunction

  function automatic logic [63:0] satv(input int v, input int mx);
    return 64'((v > mx) ? mx : v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic model_clear();
    m_seeded = 0; m_pos = 0; m_pkt = 0; m_beat = 0;
    m_derr = 0; m_lerr = 0; m_kerr = 0; m_flag = 0;
    m_cap = 0; m_cexp = 0; m_crcv = 0;
  endtask

  // Behaviour of one accepted beat: a packet is exactly c_PKT beats long,
  // the stream carries pat(seed + n) for the n-th beat after the seed.
  task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic [63:0] e;
    bit          bad;
    bad = 0;
    if (!m_ena) return;
    m_beat++;
    if (l) begin m_pkt++; m_done++; end
    if (!m_seeded) begin
      m_seeded = 1;
      m_seq = d[32:1];
    end else begin
      e = pat(m_seq);
      if (d !== e) begin
        bad = 1; m_derr++;
        if (!m_cap) begin m_cap = 1; m_cexp = e; m_crcv = d; end
      end
    end
    m_seq = m_seq + 32'd1;
    if (l != (m_pos == c_PKT - 1)) begin
      bad = 1; m_lerr++; m_pos = 0;
    end else begin
      m_pos = l ? 0 : m_pos + 1;
    end
    if (k !== 8'hFF) begin bad = 1; m_kerr++; end
    if (bad) m_flag = 1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit got;
    bit acc;
    got = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge user_clk);
      acc = (s_axis_tready === 1'b1);
      tick();
      if (acc) begin
        got = 1;
        model_beat(d, k, l);
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $error("FAIL handshake_timeout observed=no_accept expected=accept");
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic maybe_gap();
    if ($urandom_range(7) == 0) tick();
  endtask

  task automatic send_seq(input logic [31:0] c0, input int n, input int len);
    for (int i = 0; i < n; i++) begin
      send_beat(pat(c0 + 32'(i)), 8'hFF, (i % len) == len - 1);
      maybe_gap();
    end
  endtask

  task automatic restart();
    chk_ena = 1'b0; m_ena = 0;
    tick();
    chk_ena = 1'b1; m_ena = 1;
    model_clear();
  endtask

  task automatic check_all(input string t);
    @(negedge user_clk);
    #1;
    chk({t, " pkt_count"},  64'(pkt_count),      64'(m_pkt));
    chk({t, " beat_count"}, 64'(beat_count),     64'(m_beat));
    chk({t, " data_err"},   64'(data_err_count), satv(m_derr, 65535));
    chk({t, " len_err"},    64'(len_err_count),  satv(m_lerr, 65535));
    chk({t, " keep_err"},   64'(keep_err_count), satv(m_kerr, 65535));
    chk({t, " err_flag"},   64'(err_flag),       64'(m_flag));
    chk({t, " cap_exp"},    first_err_exp,       m_cexp);
    chk({t, " cap_rcv"},    first_err_rcv,       m_crcv);
    chk({t, " done_pulses"}, 64'(done_seen),     64'(m_done));
    chk({t, " sat_data_err"}, 64'(sat_data_err), satv(m_derr, 15));
    tick();
  endtask

  initial begin : main
    logic [31:0] s;
    logic [63:0] d;
    logic [7:0]  k;
    int          done0, n_acc, lows, pat_bad, first_low;
    bit          r;

    // ---------------- reset state ----------------
    repeat (3) @(negedge user_clk);
    chk("rst tready",     64'(s_axis_tready),  64'd0);
    chk("rst pkt_count",  64'(pkt_count),      64'd0);
    chk("rst beat_count", 64'(beat_count),     64'd0);
    chk("rst data_err",   64'(data_err_count), 64'd0);
    chk("rst len_err",    64'(len_err_count),  64'd0);
    chk("rst keep_err",   64'(keep_err_count), 64'd0);
    chk("rst err_flag",   64'(err_flag),       64'd0);
    chk("rst cap_exp",    first_err_exp,       64'd0);
    chk("rst cap_rcv",    first_err_rcv,       64'd0);
    chk("rst pkt_done",   64'(pkt_done),       64'd0);
    user_rstn = 1'b1;
    repeat (3) tick();
    chk("post-rst tready", 64'(s_axis_tready), 64'd1);

    // ---------------- 3 clean packets seeded at 0x100 ----------------
    restart();
    done0 = done_seen;
    send_seq(32'h0000_0100, 3 * c_PKT, c_PKT);
    check_all("t1");
    chk("t1 pkt_count const",  64'(pkt_count),  64'd3);
    chk("t1 beat_count const", 64'(beat_count), 64'd6144);
    chk("t1 err_flag const",   64'(err_flag),   64'd0);
    chk("t1 done const",       64'(done_seen - done0), 64'd3);

    // ---------------- data corruption and first-error capture ----------------
    restart();
    s = $urandom;
    for (int i = 0; i < c_PKT + 200; i++) begin
      d = pat(s + 32'(i));
      k = 8'hFF;
      if (i == c_PKT + 10)  d[5]  = ~d[5];
      if (i == c_PKT + 120) d[40] = ~d[40];
      if (i == c_PKT + 150) k = 8'h7F;
      send_beat(d, k, (i % c_PKT) == c_PKT - 1);
      if (i == c_PKT + 10) begin
        check_all("t2a");
        chk("t2a cap_xor",  first_err_exp ^ first_err_rcv, 64'h20);
        chk("t2a cap_exp const", first_err_exp, pat(s + 32'(c_PKT + 10)));
      end
      maybe_gap();
    end
    check_all("t2b");
    chk("t2b data_err const", 64'(data_err_count), 64'd2);
    chk("t2b keep_err const", 64'(keep_err_count), 64'd1);
    chk("t2b cap_rcv frozen", first_err_rcv, pat(s + 32'(c_PKT + 10)) ^ 64'h20);

    // ---------------- short packet then full packet ----------------
    restart();
    s = $urandom;
    for (int i = 0; i <= 1000; i++) send_beat(pat(s + 32'(i)), 8'hFF, i == 1000);
    check_all("t3a");
    chk("t3a len_err const", 64'(len_err_count), 64'd1);
    send_seq(s + 32'd1001, c_PKT, c_PKT);
    check_all("t3b");
    chk("t3b len_err const", 64'(len_err_count), 64'd1);
    chk("t3b pkt_count const", 64'(pkt_count), 64'd2);

    // ---------------- throttle = 3 ----------------
    throttle = 4'd3;
    repeat (8) tick();
    restart();
    s = $urandom;
    n_acc = 0; lows = 0; pat_bad = 0; first_low = -1;
    s_axis_tvalid = 1'b1; s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s_axis_tdata = pat(s + 32'(n_acc));
      @(negedge user_clk);
      r = (s_axis_tready === 1'b1);
      if (!r) begin
        lows++;
        if (first_low < 0) first_low = cyc;
        else if (((cyc - first_low) % 4) != 0) pat_bad++;
      end else if (first_low >= 0 && ((cyc - first_low) % 4) == 0) begin
        pat_bad++;
      end
      tick();
      if (r) begin
        model_beat(pat(s + 32'(n_acc)), 8'hFF, 1'b0);
        n_acc++;
      end
    end
    s_axis_tvalid = 1'b0;
    chk("t4 accepted",     64'(n_acc),   64'd300);
    chk("t4 low_cycles",   64'(lows),    64'd100);
    chk("t4 pattern_bad",  64'(pat_bad), 64'd0);
    chk("t4 first_low<4",  64'(first_low >= 0 && first_low < 4), 64'd1);
    check_all("t4");
    chk("t4 beat_count const", 64'(beat_count), 64'd300);
    throttle = 4'd0;
    repeat (8) tick();

    // ---------------- error counter saturation ----------------
    restart();
    s = $urandom;
    send_beat(pat(s), 8'hFF, 1'b0);
    for (int i = 1; i <= 20; i++) send_beat(pat(s + 32'(i)) ^ 64'h1, 8'hFF, 1'b0);
    check_all("t5a");
    chk("t5a sat const",  64'(sat_data_err),   64'd15);
    chk("t5a wide const", 64'(data_err_count), 64'd20);
    for (int i = 21; i <= 23; i++) send_beat(pat(s + 32'(i)) ^ 64'h1, 8'hFF, 1'b0);
    check_all("t5b");
    chk("t5b sat hold", 64'(sat_data_err), 64'd15);

    // ---------------- chk_ena drop mid-packet, re-enable ----------------
    restart();
    s = $urandom;
    send_seq(s, 500, c_PKT);
    chk_ena = 1'b0; m_ena = 0;
    for (int i = 0; i < 5; i++) send_beat(64'(i) * 64'h1111, 8'h0F, 1'b1);
    check_all("t6a");
    chk("t6a beat hold",    64'(beat_count),    64'd500);
    chk("t6a len_err zero", 64'(len_err_count), 64'd0);
    chk_ena = 1'b1; m_ena = 1;
    model_clear();
    tick();
    check_all("t6b");
    chk("t6b beat cleared", 64'(beat_count), 64'd0);
    send_seq(32'h0000_1234, c_PKT, c_PKT);
    check_all("t6c");
    chk("t6c pkt_count const", 64'(pkt_count),      64'd1);
    chk("t6c len_err const",   64'(len_err_count),  64'd0);
    chk("t6c data_err const",  64'(data_err_count), 64'd0);

    // ---------------- asynchronous reset mid-packet ----------------
    restart();
    s = $urandom;
    send_seq(s, 30, c_PKT);
    s_axis_tdata = pat(s + 32'd30); s_axis_tvalid = 1'b1;
    @(posedge user_clk);
    #2;
    user_rstn = 1'b0;
    #1;
    chk("arst tready",     64'(s_axis_tready), 64'd0);
    chk("arst beat_count", 64'(beat_count),    64'd0);
    chk("arst pkt_count",  64'(pkt_count),     64'd0);
    s_axis_tvalid = 1'b0;
    chk_ena = 1'b0; m_ena = 0;
    model_clear();
    @(negedge user_clk);
    user_rstn = 1'b1;
    repeat (3) tick();
    chk("arst recover tready", 64'(s_axis_tready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
